present_encrypt_core: RTL and testbench
=======================================

PRESENT_ENCRYPT_CORE -- requirements
Module: present_encrypt_core

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 80, cipher key width; legal values 80 and 128.
REQ-002 SHALL have parameter SIZE, default 64, block width; fixed at 64.
REQ-003 SHALL have parameter NUM_ROUNDS, default 32, round-key count; 31 full rounds plus a final key addition.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  plaintext and key presented.
REQ-008 in_ready  output  1  core idle; a block is accepted on in_valid&in_ready.
REQ-009 in_key  input  KEY_SIZE  cipher key, sampled on accept.
REQ-010 in_data  input  SIZE  plaintext, sampled on accept.
REQ-011 out_valid  output  1  ciphertext available.
REQ-012 out_ready  input  1  consumer takes ciphertext on out_valid&out_ready.
REQ-013 out_data  output  SIZE  ciphertext, registered.
REQ-014 busy  output  1  high in RUN state.
REQ-015 round_idx  output  5  current round counter (debug).

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, busy=1 only in RUN, out_valid=1 only in DONE.
REQ-017 On accept in IDLE: state_reg<=in_data, key_reg<=in_key, round_idx<=1, go RUN.
REQ-018 Each RUN cycle SHALL perform one round: addRoundKey (state XOR key_reg[KEY_SIZE-1 -: 64]), sBoxLayer (16 nibbles, S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F), pLayer (bit i moves to bit 16*i mod 63, bit 63 fixed).
REQ-019 Same cycle, key_reg SHALL update on the fly: rotate left 61; KEY_SIZE=80: S on bits 79:76, XOR round_idx into bits 19:15; KEY_SIZE=128: S on bits 127:124 and 123:120, XOR round_idx into bits 66:62.
REQ-020 round_idx SHALL increment by 1 per RUN cycle; rounds 1..31 execute; no wrap past 31.
REQ-021 On the RUN cycle with round_idx=31, out_data SHALL load the round-31 result XOR the top 64 bits of the updated key (K32), and FSM goes DONE.
REQ-022 Latency: out_valid SHALL rise exactly 31 clock cycles after the accepting edge; throughput one block per 32+ cycles.
REQ-023 In DONE, out_data and out_valid SHALL hold stable until out_ready=1; then FSM goes IDLE, in_ready=1 next cycle.
REQ-024 in_valid during RUN or DONE SHALL be ignored; in_key/in_data changes after accept SHALL not affect the result.
REQ-025 out_ready while not in DONE SHALL have no effect.
REQ-026 A new block SHALL NOT be accepted in the same cycle as the DONE handshake (no bypass).

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, busy=0, round_idx=0, out_data=0, state_reg=0, key_reg=0, regardless of current state.
REQ-028 rst SHALL take priority over any handshake in the same cycle; an in-flight block is discarded and never emitted.

Verification
REQ-029 KEY_SIZE=80, key 0, plaintext 0 -> out_data 5579C1387B228445, out_valid 31 cycles after accept.
REQ-030 KEY_SIZE=80, key FFFFFFFFFFFFFFFFFFFF, plaintext 0 -> E72C46C0F5945049; key 0, plaintext FFFFFFFFFFFFFFFF -> A112FFC72F68417B.
REQ-031 KEY_SIZE=80, key and plaintext all ones, out_ready held 0 for 10 cycles after out_valid -> 3333DCD3213210D2 held stable, in_ready stays 0, in_valid pulses ignored.
REQ-032 Assert rst at round_idx=15 -> next cycle IDLE, all outputs at reset values; subsequent block 0/0 yields 5579C1387B228445 with correct latency.
REQ-033 Back-to-back: in_valid held high with two vectors, out_ready=1 -> two correct ciphertexts, second accept one cycle after first DONE handshake, busy and round_idx sequence 1..31 checked each block.

Source files
------------

// File: rtl/present_encrypt_core_if.sv
// present_encrypt_core_if
//   Groups the plaintext/key input channel, the ciphertext output channel
//   and the debug status of the PRESENT encryption core.
//   Signals:
//     in_valid  - plaintext and key presented by the producer
//     in_ready  - core idle, accepts a block on in_valid & in_ready
//     in_key    - cipher key (KEY_SIZE bits)
//     in_data   - plaintext block (SIZE bits)
//     out_valid - ciphertext available
//     out_ready - consumer takes the ciphertext on out_valid & out_ready
//     out_data  - ciphertext block (SIZE bits)
//     busy      - core is executing rounds
//     round_idx - current round counter (debug)
//   Modports: master = producer/consumer side, slave = core side.
interface present_encrypt_core_if #(
  parameter int KEY_SIZE = 80,
  parameter int SIZE     = 64
) ();
  logic                in_valid;
  logic                in_ready;
  logic [KEY_SIZE-1:0] in_key;
  logic [SIZE-1:0]     in_data;
  logic                out_valid;
  logic                out_ready;
  logic [SIZE-1:0]     out_data;
  logic                busy;
  logic [4:0]          round_idx;

  modport master (
    output in_valid, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, round_idx
  );

  modport slave (
    input  in_valid, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, round_idx
  );
endinterface

// File: rtl/present_encrypt_core.sv
// present_encrypt_core
//   Iterative PRESENT block cipher encryption, one round per clock.
//   A block is accepted in IDLE, rounds 1..31 run in RUN with the key
//   schedule computed on the fly, and the whitened ciphertext is held in
//   DONE until the consumer takes it.
//   Ports:
//     clk - rising-edge clock for all state
//     rst - synchronous active-high reset
//     bus - present_encrypt_core_if.slave (handshakes, data, debug status)
module present_encrypt_core #(
  parameter int KEY_SIZE   = 80,
  parameter int SIZE       = 64,
  parameter int NUM_ROUNDS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  present_encrypt_core_if.slave  bus
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t                fsm_r, fsm_next_s;
  logic [SIZE-1:0]     state_r, state_next_s;
  logic [KEY_SIZE-1:0] key_r, key_next_s;
  logic [4:0]          round_idx_r, round_idx_next_s;
  logic [SIZE-1:0]     out_data_r, out_data_next_s;
  logic                in_ready_r, out_valid_r, busy_r;
  logic [SIZE-1:0]     round_out_s;
  logic [KEY_SIZE-1:0] key_rot_s, key_upd_s;

  // 4-bit PRESENT substitution box
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    o = 64'd0;
    for (int n = 0; n < 16; n++) begin
      o[4*n +: 4] = sbox(s[4*n +: 4]);
    end
    return o;
  endfunction

  // Bit i lands on 16*i mod 63; bit 63 is a fixed point of the permutation.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] o;
    o = 64'd0;
    for (int i = 0; i < 63; i++) begin
      o[(16*i) % 63] = s[i];
    end
    o[63] = s[63];
    return o;
  endfunction

  // One full round: add round key, substitution, permutation
  always_comb begin
    round_out_s = p_layer(sbox_layer(state_r ^ key_r[KEY_SIZE-1 -: 64]));
  end

  generate
    if (KEY_SIZE == 128) begin : g_key128
      // 128-bit key schedule: rotate left 61, two S-boxes, round counter XOR
      always_comb begin
        key_rot_s          = {key_r[66:0], key_r[127:67]};
        key_upd_s          = key_rot_s;
        key_upd_s[127:124] = sbox(key_rot_s[127:124]);
        key_upd_s[123:120] = sbox(key_rot_s[123:120]);
        key_upd_s[66:62]   = key_rot_s[66:62] ^ round_idx_r;
      end
    end else begin : g_key80
      // 80-bit key schedule: rotate left 61, one S-box, round counter XOR
      always_comb begin
        key_rot_s        = {key_r[18:0], key_r[79:19]};
        key_upd_s        = key_rot_s;
        key_upd_s[79:76] = sbox(key_rot_s[79:76]);
        key_upd_s[19:15] = key_rot_s[19:15] ^ round_idx_r;
      end
    end
  endgenerate

  // FSM next state and datapath next values
  always_comb begin
    fsm_next_s       = fsm_r;
    state_next_s     = state_r;
    key_next_s       = key_r;
    round_idx_next_s = round_idx_r;
    out_data_next_s  = out_data_r;
    case (fsm_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_next_s     = bus.in_data;
          key_next_s       = bus.in_key;
          round_idx_next_s = 5'd1;
          fsm_next_s       = S_RUN;
        end else begin
          fsm_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        state_next_s = round_out_s;
        key_next_s   = key_upd_s;
        if (round_idx_r == LAST_ROUND) begin
          // final whitening with K32; the counter stays at the last round
          out_data_next_s = round_out_s ^ key_upd_s[KEY_SIZE-1 -: 64];
          fsm_next_s      = S_DONE;
        end else begin
          round_idx_next_s = round_idx_r + 5'd1;
          fsm_next_s       = S_RUN;
        end
      end
      S_DONE: begin
        // no bypass: IDLE is entered first, a new block is taken next cycle
        if (bus.out_ready) begin
          fsm_next_s = S_IDLE;
        end else begin
          fsm_next_s = S_DONE;
        end
      end
      default: begin
        fsm_next_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= S_IDLE;
      state_r     <= {SIZE{1'b0}};
      key_r       <= {KEY_SIZE{1'b0}};
      round_idx_r <= 5'd0;
      out_data_r  <= {SIZE{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      fsm_r       <= fsm_next_s;
      state_r     <= state_next_s;
      key_r       <= key_next_s;
      round_idx_r <= round_idx_next_s;
      out_data_r  <= out_data_next_s;
      in_ready_r  <= (fsm_next_s == S_IDLE);
      out_valid_r <= (fsm_next_s == S_DONE);
      busy_r      <= (fsm_next_s == S_RUN);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = busy_r;
  assign bus.round_idx = round_idx_r;

endmodule

// File: tb/tb_present_encrypt_core.sv
// tb_present_encrypt_core
//   Directed self-checking bench for present_encrypt_core (KEY_SIZE=80)
//   using the published PRESENT-80 test vectors. Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_present_encrypt_core;

  localparam logic [79:0] KEY_ZERO = 80'h0;
  localparam logic [79:0] KEY_ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PT_ZERO  = 64'h0;
  localparam logic [63:0] PT_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CT_00    = 64'h5579_C138_7B22_8445;
  localparam logic [63:0] CT_K1    = 64'hE72C_46C0_F594_5049;
  localparam logic [63:0] CT_P1    = 64'hA112_FFC7_2F68_417B;
  localparam logic [63:0] CT_11    = 64'h3333_DCD3_2132_10D2;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  present_encrypt_core_if #(.KEY_SIZE(80), .SIZE(64)) bus ();

  present_encrypt_core #(
    .KEY_SIZE   (80),
    .SIZE       (64),
    .NUM_ROUNDS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_busy"},      64'(bus.busy),      64'd0);
    check_eq({tag, "_round_idx"}, 64'(bus.round_idx), 64'd0);
    check_eq({tag, "_out_data"},  bus.out_data,       64'd0);
  endtask

  // Present a block at the current falling edge; returns one cycle later,
  // right after the accepting rising edge.
  task automatic accept_block(input string tag, input logic [79:0] key, input logic [63:0] pt);
    bus.in_valid = 1'b1;
    bus.in_key   = key;
    bus.in_data  = pt;
    check_eq({tag, "_accept_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
  endtask

  // Follow rounds 1..31, then check the ciphertext exactly 31 cycles after
  // the accept. Optionally disturbs inputs while the core is running.
  task automatic track_run(input string tag, input logic [63:0] exp, input bit garble,
                           input logic last_valid, input logic last_ready);
    for (int cyc = 1; cyc <= 31; cyc++) begin
      check_eq($sformatf("%s_idx%0d", tag, cyc), 64'(bus.round_idx), 64'(cyc));
      check_eq($sformatf("%s_busy%0d", tag, cyc), 64'(bus.busy), 64'd1);
      if (cyc == 31) begin
        check_eq({tag, "_early_valid"}, 64'(bus.out_valid), 64'd0);
        bus.in_valid  = last_valid;
        bus.out_ready = last_ready;
      end else if (garble) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_key    = 80'({$urandom(), $urandom(), $urandom()});
        bus.in_data   = {$urandom(), $urandom()};
        bus.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.out_ready = bus.out_ready;
      end
      @(negedge clk);
    end
    check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check_eq({tag, "_out_data"},  bus.out_data,       exp);
    check_eq({tag, "_busy_done"}, 64'(bus.busy),      64'd0);
    check_eq({tag, "_ready_done"}, 64'(bus.in_ready), 64'd0);
  endtask

  // Called one cycle after a DONE handshake
  task automatic check_back_idle(input string tag);
    check_eq({tag, "_idle_ready"}, 64'(bus.in_ready),  64'd1);
    check_eq({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_idle_busy"},  64'(bus.busy),      64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_key    = KEY_ZERO;
    bus.in_data   = PT_ZERO;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // out_ready while idle has no effect
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("idle_oready_valid", 64'(bus.out_valid), 64'd0);
    check_eq("idle_oready_ready", 64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b0;

    // key 0 / plaintext 0, inputs disturbed during RUN
    accept_block("t1", KEY_ZERO, PT_ZERO);
    track_run("t1", CT_00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_back_idle("t1");
    bus.out_ready = 1'b0;

    // key all ones / plaintext 0, in_valid left high during RUN
    accept_block("t2", KEY_ONES, PT_ZERO);
    track_run("t2", CT_K1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_back_idle("t2");
    bus.out_ready = 1'b0;

    // key 0 / plaintext all ones
    accept_block("t3", KEY_ZERO, PT_ONES);
    track_run("t3", CT_P1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_back_idle("t3");
    bus.out_ready = 1'b0;

    // all ones, consumer stalls 10 cycles while in_valid pulses
    accept_block("t4", KEY_ONES, PT_ONES);
    track_run("t4", CT_11, 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 10; h++) begin
      check_eq($sformatf("t4_hold_data%0d", h),  bus.out_data,       CT_11);
      check_eq($sformatf("t4_hold_valid%0d", h), 64'(bus.out_valid), 64'd1);
      check_eq($sformatf("t4_hold_ready%0d", h), 64'(bus.in_ready),  64'd0);
      bus.in_valid = ((h % 2) == 0);
      @(negedge clk);
    end
    check_eq("t4_hold_data_end", bus.out_data, CT_11);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_back_idle("t4");
    bus.out_ready = 1'b0;

    // reset at round 15 discards the block
    accept_block("t5", KEY_ZERO, PT_ZERO);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 1; cyc < 15; cyc++) begin
      @(negedge clk);
    end
    check_eq("t5_idx_before_rst", 64'(bus.round_idx), 64'd15);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("t5_rst");
    rst = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_no_emit", 64'(bus.out_valid), 64'd0);
    accept_block("t5b", KEY_ZERO, PT_ZERO);
    track_run("t5b", CT_00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_back_idle("t5b");
    bus.out_ready = 1'b0;

    // back-to-back: in_valid held high, vector 2 presented after first accept
    bus.out_ready = 1'b1;
    accept_block("b1", KEY_ZERO, PT_ZERO);
    bus.in_key  = KEY_ONES;
    bus.in_data = PT_ZERO;
    track_run("b1", CT_00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_back_idle("b1");
    @(negedge clk);
    bus.in_valid = 1'b0;
    track_run("b2", CT_K1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_back_idle("b2");
    bus.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
